// File: rtl/seg7_bcd_counter.sv
// seg7_bcd_counter: multi-digit BCD up/down counter with a time-multiplexed
// seven-segment driver.
// - A prescaler divides enabled cycles down to count ticks.
// - A free-running scan divider selects which digit is driven.
// - seg, dp and digit_sel are registered together on the same edge.
// Optional feature: define SEG7_LEADING_ZERO_BLANK_EN to blank leading zero
// digits on seg. Digit 0 is never blanked. The scan order does not change.
`timescale 1ns/1ps

module seg7_bcd_counter #(
    parameter int DIGITS   = 2,
    parameter int TICK_DIV = 4,
    parameter int SCAN_DIV = 2
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  en,
    input  logic                  dir,
    input  logic                  load,
    input  logic [4*DIGITS-1:0]   preset,
    output logic [4*DIGITS-1:0]   count,
    output logic                  wrap,
    output logic [6:0]            seg,
    output logic                  dp,
    output logic [DIGITS-1:0]     digit_sel
);

    localparam int PW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam int SW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
    localparam int IW = (DIGITS   > 1) ? $clog2(DIGITS)   : 1;

    localparam logic [PW-1:0] PRE_LAST  = PW'(TICK_DIV - 1);
    localparam logic [SW-1:0] SCAN_LAST = SW'(SCAN_DIV - 1);
    localparam logic [IW-1:0] IDX_LAST  = IW'(DIGITS - 1);

    logic [PW-1:0]     presc;
    logic [SW-1:0]     scan_cnt;
    logic [IW-1:0]     idx;
    logic              tick;
    logic [3:0]        cur_digit;
    logic [DIGITS-1:0] sel_onehot;
    logic              blank;

    // Nibbles above 9 are not valid BCD and load as 0.
    function automatic logic [4*DIGITS-1:0] sanitize(input logic [4*DIGITS-1:0] v);
        logic [4*DIGITS-1:0] r;
        r = v;
        for (int i = 0; i < DIGITS; i++) begin
            if (v[4*i +: 4] > 4'd9)
                r[4*i +: 4] = 4'd0;
        end
        return r;
    endfunction

    // One BCD step up or down.
    // The MSB of the result is the carry or borrow out of the top digit.
    // That bit is the wrap condition.
    function automatic logic [4*DIGITS:0] bcd_step(input logic [4*DIGITS-1:0] v,
                                                   input logic down);
        logic [4*DIGITS-1:0] r;
        logic                c;
        logic [3:0]          d;
        r = v;
        c = 1'b1;
        for (int i = 0; i < DIGITS; i++) begin
            d = v[4*i +: 4];
            if (c) begin
                if (!down) begin
                    if (d == 4'd9) begin
                        d = 4'd0;
                        c = 1'b1;
                    end else begin
                        d = d + 4'd1;
                        c = 1'b0;
                    end
                end else begin
                    if (d == 4'd0) begin
                        d = 4'd9;
                        c = 1'b1;
                    end else begin
                        d = d - 4'd1;
                        c = 1'b0;
                    end
                end
            end
            r[4*i +: 4] = d;
        end
        return {c, r};
    endfunction

    // Seven-segment pattern {g,f,e,d,c,b,a}, active-high.
    function automatic logic [6:0] decode(input logic [3:0] d);
        case (d)
            4'd0:    return 7'b0111111;
            4'd1:    return 7'b0000110;
            4'd2:    return 7'b1011011;
            4'd3:    return 7'b1001111;
            4'd4:    return 7'b1100110;
            4'd5:    return 7'b1101101;
            4'd6:    return 7'b1111101;
            4'd7:    return 7'b0000111;
            4'd8:    return 7'b1111111;
            4'd9:    return 7'b1101111;
            default: return 7'b0000000;
        endcase
    endfunction

    assign tick = en && (presc == PRE_LAST);

    // Select the digit being scanned, its one-hot enable and its blanking.
    always_comb begin
        cur_digit  = 4'd0;
        sel_onehot = '0;
        blank      = 1'b0;
        for (int i = 0; i < DIGITS; i++) begin
            if (idx == IW'(i)) begin
                cur_digit     = count[4*i +: 4];
                sel_onehot[i] = 1'b1;
`ifdef SEG7_LEADING_ZERO_BLANK_EN
                if (i > 0 && (count >> (4*i)) == '0)
                    blank = 1'b1;
`endif
            end
        end
    end

    // Prescaler and count.
    // A load overrides a tick and restarts the prescaler.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            count <= '0;
            wrap  <= 1'b0;
            presc <= '0;
        end else if (load) begin
            count <= sanitize(preset);
            wrap  <= 1'b0;
            presc <= '0;
        end else if (tick) begin
            {wrap, count} <= bcd_step(count, dir);
            presc         <= '0;
        end else begin
            wrap <= 1'b0;
            if (en)
                presc <= presc + PW'(1);
        end
    end

    // Free-running scan divider; the digit index advances on each divider wrap.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            scan_cnt <= '0;
            idx      <= '0;
        end else if (scan_cnt == SCAN_LAST) begin
            scan_cnt <= '0;
            idx      <= (idx == IDX_LAST) ? '0 : idx + IW'(1);
        end else begin
            scan_cnt <= scan_cnt + SW'(1);
        end
    end

    // Display registers.
    // seg and digit_sel load on the same edge, so no digit shows another digit's segments.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            seg       <= '0;
            dp        <= 1'b0;
            digit_sel <= '0;
        end else begin
            seg       <= blank ? 7'b0000000 : decode(cur_digit);
            dp        <= (idx == '0) && !en;
            digit_sel <= sel_onehot;
        end
    end

endmodule
